mux_arb_nx1: RTL and testbench
==============================

Name: mux_arb_nx1

Overview:
- Parametrised N-to-1 data multiplexer with valid/ready handshake on every channel and a registered output stage.
- Two selection modes: round-robin arbitration across all valid channels, or fixed selection by a `sel` input (the classic mux mode).
- Sits between multiple producer channels and a single downstream consumer, as the successor to the combinational 4x1 mux.

Parameters:
- N_CH, 4, number of input channels (>=2).
- DATA_W, 1, width of each channel's data in bits.
- SEL_W, $clog2(N_CH), width of the `sel` and `out_sel` fields. Derived localparam; never overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
- in_data  input  N_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready, combinational.
- out_data  output  DATA_W  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer `last` = N_CH-1, so the first round-robin grant after reset goes to channel 0.
- Load enable: `load = !out_valid || out_ready`. The output register accepts new data only when `load`=1.
- Grant, combinational, at most one bit set:
  - Fixed mode:
    - grant[sel] = in_valid[sel]; no other channel is granted.
    - sel >= N_CH grants nothing.
  - Round-robin mode:
    - Grant the first k with in_valid[k]=1, searching last+1, last+2, ... and wrapping modulo N_CH.
    - `last` itself has the lowest priority.
- in_ready[k] = load && grant[k].
- Transfer on channel k: in_valid[k] && in_ready[k] at a rising edge.
  - Next state: out_data <= channel k data, out_sel <= k, out_valid <= 1.
  - `last` <= k. The pointer updates in both modes, so the fixed-mode history carries into round-robin.
- Output transfer with no new input: out_valid && out_ready and no grant → out_valid <= 0; out_data and out_sel hold their values.
- Stall: out_valid=1 && out_ready=0:
  - out_data, out_sel and out_valid hold.
  - All in_ready = 0.
  - `last` holds.
- Simultaneous drain and fill: out_valid && out_ready with a granted input → register reloads in the same cycle and out_valid stays 1. Sustained throughput is one word per cycle.
- Latency: an accepted input appears on out_data on the next rising edge (1 cycle).
- No grant and `load`=1: no state change except out_valid <= 0.
- Changes to mode or sel take effect on the grant in the same cycle. They never modify held output data.
- Reset asserted mid-transfer: the output is cleared immediately. In-flight data is discarded and not replayed.
- Single-channel contention with N_CH-1 channels idle: that channel is granted every cycle. No bubble is inserted by the pointer.

Decomposition:
- Package `mux_arb_pkg`:
  - MODE_RR = 1'b0, MODE_FIXED = 1'b1.
  - A function for ceil-log2 used to derive SEL_W.
- Sub-module `rr_grant`:
  - Combinational rotate-priority finder.
  - Inputs: req[N_CH], last[SEL_W].
  - Outputs: grant[N_CH] (one-hot or zero) and grant_idx[SEL_W].
  - Fixed-mode grant is done in the top level.

Test Plan:
1. Reset, then N_CH=4, DATA_W=8, mode=RR, all in_valid=1, in_data = {8'h33, 8'h22, 8'h11, 8'h00}, out_ready=1 → out_sel sequence 0, 1, 2, 3, 0 on consecutive cycles; out_data 00, 11, 22, 33, 00; out_valid=1 from cycle 1 on.
2. mode=FIXED, sel=2, all channels valid → only in_ready[2] asserts; out_data=22 every cycle. Then sel=3 → out_data=33 on the next cycle.
3. Backpressure: RR, all valid, out_ready=0 for 3 cycles after the first load → out_data=00 held, in_ready=0000 throughout. Release → next out_sel=1.
4. Sparse requests: last=0, in_valid=1001 → grant ch3; next cycle in_valid=1001 → grant ch0 (wrap-around).
5. Reset mid-stream: assert rst_n=0 while out_valid=1 → out_valid, out_data and out_sel go to 0 without waiting for a clock edge. After release with all channels valid → first grant is ch0.
6. Drain with no requests: out_valid=1, out_ready=1, in_valid=0000 → out_valid=0 next cycle; out_data unchanged.

Source files
------------

// File: rtl/mux_arb_nx1_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the N-to-1 arbitrating multiplexer:
//   MODE_RR / MODE_FIXED : values of the `mode` input
//   clog2()              : ceil-log2 helper used to size channel indices
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceil-log2, floored at 1 so that a channel index is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nx1_if.sv
// -----------------------------------------------------------------------------
// mux_arb_nx1_if
// Bus bundle between N producer channels, the arbitrating mux and one consumer.
//
// Handshake: a channel word moves when valid && ready are both high at a rising
// clock edge. A producer holds valid (and its data) until it sees ready; ready
// may depend combinationally on valid, valid never depends on ready.
//
// Signals (direction seen from the mux, i.e. the slave modport):
//   mode      in   0 = round-robin, 1 = fixed select
//   sel       in   channel index used in fixed mode
//   in_data   in   packed channel data, channel k at [k*DATA_W +: DATA_W]
//   in_valid  in   per-channel valid
//   in_ready  out  per-channel ready (combinational)
//   out_data  out  registered selected data
//   out_valid out  registered valid
//   out_sel   out  index of the channel that supplied out_data
//   out_ready in   downstream ready
//   dbg_last  out  round-robin pointer (last granted channel), for observation
// -----------------------------------------------------------------------------
interface mux_arb_nx1_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 1
);
  import mux_arb_pkg::*;

  localparam int SEL_W = clog2(N_CH);

  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;
  logic [SEL_W-1:0]         dbg_last;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel, dbg_last
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel, dbg_last
  );

endinterface

// File: rtl/mux_arb_nx1_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational rotating-priority finder. Searches req starting at last+1 and
// wrapping modulo N_CH, so the channel at `last` has the lowest priority.
//   req       in   request vector
//   last      in   index of the most recently granted channel
//   grant     out  one-hot grant, or zero when nothing requests
//   grant_idx out  index of the granted channel (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  always_comb begin
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      int idx;
      // last < N_CH and off <= N_CH, so one subtraction is enough to wrap.
      idx = int'(last) + off;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// -----------------------------------------------------------------------------
// mux_arb_nx1
// N-to-1 data multiplexer with per-channel valid/ready and a registered output.
// Selection is either round-robin over all valid channels or fixed by `sel`.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of mux_arb_nx1_if (channels in, single stream out)
//
// The output register loads whenever it is empty or being drained this cycle,
// giving one word per cycle sustained throughput with one cycle of latency.
// The round-robin pointer follows every accepted word in either mode, so a
// fixed-mode history carries into round-robin.
// -----------------------------------------------------------------------------
module mux_arb_nx1
  import mux_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arb_nx1_if.slave  bus
);

  localparam int SEL_W = clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_CH - 1);

  // Registered state
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  last_q,      last_d;

  // Grant path
  logic              load;
  logic [N_CH-1:0]   rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic [N_CH-1:0]   fix_gnt;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_grant;
  logic [DATA_W-1:0] data_sel;

  rr_grant #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_grant (
    .req       (bus.in_valid),
    .last      (last_q),
    .grant     (rr_gnt),
    .grant_idx (rr_idx)
  );

  always_comb begin
    load = !out_valid_q || bus.out_ready;

    // Fixed mode: only the selected channel can win; an out-of-range sel
    // (possible when N_CH is not a power of two) grants nothing.
    fix_gnt = '0;
    if (int'(bus.sel) < N_CH) begin
      fix_gnt[bus.sel] = bus.in_valid[bus.sel];
    end

    if (bus.mode == MODE_FIXED) begin
      grant     = fix_gnt;
      grant_idx = bus.sel;
    end else begin
      grant     = rr_gnt;
      grant_idx = rr_idx;
    end

    any_grant = |grant;

    // One-hot mux keeps the data path free of variable part-selects.
    data_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) begin
        data_sel = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      if (any_grant) begin
        out_data_d  = data_sel;
        out_sel_d   = grant_idx;
        out_valid_d = 1'b1;
        last_d      = grant_idx;
      end else begin
        // Drained (or idle) with nothing to take: data and sel keep their
        // last values, only valid drops.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = load ? grant : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dbg_last  = last_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_nx1
// Self-checking bench for mux_arb_nx1 with N_CH=4, DATA_W=8. A small reference
// model tracks the pointer and output valid; every accepted input word is
// pushed to exp_q and popped when the consumer takes the output word.
// -----------------------------------------------------------------------------
module tb_mux_arb_nx1;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int W      = SEL_W + DATA_W;

  logic clk;
  logic rst_n;

  mux_arb_nx1_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bif ();

  mux_arb_nx1 #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic             m_valid;
  int               m_last;
  int               n_vec;
  int               n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = N_CH - 1;
    exp_q.delete();
  endtask

  // One clock cycle: check combinational/registered outputs against the
  // model on the falling edge, advance the model, then return just after the
  // rising edge so the caller can drive the next inputs.
  task automatic step();
    logic [N_CH-1:0] g;
    logic            ld;
    logic [W-1:0]    w;
    int              gi;
    int              c;
    @(negedge clk);
    ld = !m_valid || bif.out_ready;
    g  = '0;
    gi = -1;
    if (bif.mode) begin
      if (bif.in_valid[bif.sel]) gi = int'(bif.sel);
    end else begin
      for (int off = 1; off <= N_CH; off++) begin
        c = (m_last + off) % N_CH;
        if (gi < 0 && bif.in_valid[c]) gi = c;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    chk("in_ready", 32'(bif.in_ready), 32'(ld ? g : 4'b0000));
    chk("out_valid", 32'(bif.out_valid), 32'(m_valid));
    chk("last_ptr", 32'(bif.dbg_last), 32'(m_last));
    if (m_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_pop_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", 32'(bif.out_data), 32'(w[DATA_W-1:0]));
        chk("sb_sel", 32'(bif.out_sel), 32'(w[W-1:DATA_W]));
      end
    end
    if (ld) begin
      if (gi >= 0) begin
        exp_q.push_back({SEL_W'(gi), bif.in_data[gi*DATA_W +: DATA_W]});
        m_last  = gi;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n         = 1'b0;
    bif.mode      = 1'b0;
    bif.sel       = '0;
    bif.in_data   = '0;
    bif.in_valid  = '0;
    bif.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_out_data", 32'(bif.out_data), 32'd0);
    chk("rst_out_sel", 32'(bif.out_sel), 32'd0);
    chk("rst_last", 32'(bif.dbg_last), 32'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Round-robin, all valid
    bif.mode      = 1'b0;
    bif.in_valid  = 4'b1111;
    bif.in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
    bif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq_sel", 32'(bif.out_sel), 32'(i % 4));
      chk("rr_seq_data", 32'(bif.out_data), 32'((i % 4) * 8'h11));
      chk("rr_seq_valid", 32'(bif.out_valid), 32'd1);
    end

    // 2. Fixed select
    bif.mode = 1'b1;
    bif.sel  = 2'd2;
    #1;
    chk("fix_in_ready", 32'(bif.in_ready), 32'b0100);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fix_data", 32'(bif.out_data), 32'h22);
    end
    bif.sel = 2'd3;
    step();
    chk("fix_data_sel3", 32'(bif.out_data), 32'h33);

    // 3. Backpressure
    bif.mode = 1'b0;
    step();
    chk("bp_first", 32'(bif.out_sel), 32'd0);
    bif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
      step();
      chk("bp_hold_data", 32'(bif.out_data), 32'h00);
      chk("bp_hold_sel", 32'(bif.out_sel), 32'd0);
    end
    bif.out_ready = 1'b1;
    step();
    chk("bp_release_sel", 32'(bif.out_sel), 32'd1);

    // 4. Sparse requests with wrap-around
    bif.in_valid = 4'b0001;
    step();
    chk("sparse_last0", 32'(bif.dbg_last), 32'd0);
    bif.in_valid = 4'b1001;
    step();
    chk("sparse_ch3", 32'(bif.out_sel), 32'd3);
    chk("sparse_ch3_data", 32'(bif.out_data), 32'h33);
    step();
    chk("sparse_wrap", 32'(bif.out_sel), 32'd0);

    // 5. Asynchronous reset mid-stream
    bif.in_valid = 4'b0100;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("arst_out_data", 32'(bif.out_data), 32'd0);
    chk("arst_out_sel", 32'(bif.out_sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bif.in_valid = 4'b1111;
    step();
    chk("arst_first_grant", 32'(bif.out_sel), 32'd0);

    // 6. Drain with no requests
    bif.mode = 1'b1;
    bif.sel  = 2'd2;
    step();
    bif.in_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(bif.out_valid), 32'd0);
    chk("drain_data_hold", 32'(bif.out_data), 32'h22);
    chk("drain_sel_hold", 32'(bif.out_sel), 32'd2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bif.mode      = 1'($urandom_range(0, 1));
      bif.sel       = 2'($urandom_range(0, 3));
      bif.in_valid  = 4'($urandom_range(0, 15));
      bif.in_data   = $urandom;
      bif.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain everything that is still held
    bif.in_valid  = 4'b0000;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
